// File: rtl/fifo_stream_reader_pkg.sv
// Shared constants for the FIFO read-side stream adapter and its packet beat counter.
package fifo_stream_reader_pkg;
  localparam int BUF_DEPTH  = 4;
  localparam int BUF_AWIDTH = 2;
  localparam int DEF_DWIDTH = 32;
  localparam int DEF_LWIDTH = 16;
endpackage

// File: rtl/fifo_stream_reader_beat_counter.sv
// Per-packet beat counter: tracks beat position, derives the last-beat flag and a
// registered packet-done pulse. Shared with the write-side packetizer.
module stream_beat_counter
  import fifo_stream_reader_pkg::*;
#(
  parameter int LWIDTH = DEF_LWIDTH
) (
  input  logic              clk,
  input  logic              srst,
  input  logic [LWIDTH-1:0] cfg_len,
  input  logic              beat_valid,
  input  logic              beat_ready,
  output logic              beat_last,
  output logic              pkt_done
);

  logic [LWIDTH-1:0] beat_cnt;
  logic [LWIDTH-1:0] len_q;
  logic [LWIDTH-1:0] len_first;
  logic [LWIDTH-1:0] len_eff;
  logic              accept;

  // The first beat uses the live cfg_len; later beats use the value latched with it.
  assign len_first = (cfg_len == '0) ? LWIDTH'(1) : cfg_len;
  assign len_eff   = (beat_cnt == '0) ? len_first : len_q;
  assign beat_last = beat_valid && (beat_cnt == len_eff - LWIDTH'(1));
  assign accept    = beat_valid && beat_ready;

  always_ff @(posedge clk or posedge srst) begin
    if (srst) begin
      beat_cnt <= '0;
      len_q    <= '0;
      pkt_done <= 1'b0;
    end else begin
      pkt_done <= accept && beat_last;
      if (accept) begin
        if (beat_cnt == '0) len_q <= len_first;
        beat_cnt <= beat_last ? '0 : beat_cnt + LWIDTH'(1);
      end
    end
  end

endmodule

// File: rtl/fifo_stream_reader.sv
// Reads a 1-cycle-latency sync FIFO and re-presents its data as a valid/ready stream,
// absorbing the read latency in a small credit-managed buffer.
module fifo_stream_reader
  import fifo_stream_reader_pkg::*;
#(
  parameter int DWIDTH = DEF_DWIDTH,
  parameter int LWIDTH = DEF_LWIDTH
) (
  input  logic              clk,
  input  logic              srst,
  input  logic [DWIDTH-1:0] fifo_dout,
  input  logic              fifo_valid,
  input  logic              fifo_empty,
  output logic              fifo_rd_en,
  input  logic [LWIDTH-1:0] cfg_len,
  output logic [DWIDTH-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              m_last,
  output logic              pkt_done,
  output logic              err
);

  localparam logic [BUF_AWIDTH:0]   DEPTH_C  = (BUF_AWIDTH+1)'(BUF_DEPTH);
  localparam logic [BUF_AWIDTH+1:0] CREDIT_C = (BUF_AWIDTH+2)'(BUF_DEPTH);

  logic [DWIDTH-1:0]     buf_mem [BUF_DEPTH];
  logic [BUF_AWIDTH-1:0] wr_ptr;
  logic [BUF_AWIDTH-1:0] rd_ptr;
  logic [BUF_AWIDTH:0]   count;
  logic                  inflight;
  logic                  full;
  logic                  push;
  logic                  pop;

  assign full    = (count == DEPTH_C);
  assign m_valid = (count != '0);
  assign pop     = m_valid && m_ready;
  assign push    = fifo_valid && (!full || pop);
  assign m_data  = m_valid ? buf_mem[rd_ptr] : '0;

  // Credit covers buffered words plus the one outstanding read, so a returning word
  // always finds space; m_ready deliberately plays no part here.
  assign fifo_rd_en = !srst && !fifo_empty &&
                      (({1'b0, count} + (BUF_AWIDTH+2)'(inflight)) < CREDIT_C);

  always_ff @(posedge clk) begin
    if (push) buf_mem[wr_ptr] <= fifo_dout;
  end

  always_ff @(posedge clk or posedge srst) begin
    if (srst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      inflight <= 1'b0;
      err      <= 1'b0;
    end else begin
      inflight <= fifo_rd_en;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (fifo_valid && (!inflight || (full && !pop))) err <= 1'b1;
    end
  end

  stream_beat_counter #(
    .LWIDTH(LWIDTH)
  ) u_beat_counter (
    .clk       (clk),
    .srst      (srst),
    .cfg_len   (cfg_len),
    .beat_valid(m_valid),
    .beat_ready(m_ready),
    .beat_last (m_last),
    .pkt_done  (pkt_done)
  );

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Directed bench for fifo_stream_reader with a behavioural 1-cycle-latency upstream FIFO.
module tb_fifo_stream_reader;

  logic        clk;
  logic        srst;
  logic [31:0] fifo_dout;
  logic        fifo_valid;
  logic        fifo_empty;
  logic        fifo_rd_en;
  logic [15:0] cfg_len;
  logic [31:0] m_data;
  logic        m_valid;
  logic        m_ready;
  logic        m_last;
  logic        pkt_done;
  logic        err;

  fifo_stream_reader #(.DWIDTH(32), .LWIDTH(16)) dut (
    .clk       (clk),
    .srst      (srst),
    .fifo_dout (fifo_dout),
    .fifo_valid(fifo_valid),
    .fifo_empty(fifo_empty),
    .fifo_rd_en(fifo_rd_en),
    .cfg_len   (cfg_len),
    .m_data    (m_data),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_last    (m_last),
    .pkt_done  (pkt_done),
    .err       (err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Upstream FIFO model: words queued by the stimulus, returned one cycle after rd_en.
  logic [31:0] mem [0:255];
  int          head = 0;
  int          tail = 0;
  logic        mdl_valid;
  logic [31:0] mdl_dout;
  logic        inj_valid;
  logic [31:0] inj_dout;

  assign fifo_empty = (head == tail);
  assign fifo_valid = mdl_valid | inj_valid;
  assign fifo_dout  = inj_valid ? inj_dout : mdl_dout;

  always @(posedge clk or posedge srst) begin
    if (srst) begin
      mdl_valid <= 1'b0;
      mdl_dout  <= '0;
    end else begin
      mdl_valid <= fifo_rd_en;
      if (fifo_rd_en && !fifo_empty) begin
        mdl_dout <= mem[head];
        head     <= head + 1;
      end
    end
  end

  // Output monitor: logs accepted beats and tracks protocol properties.
  logic [31:0] acc_data [0:255];
  logic        acc_last [0:255];
  int          acc_cyc  [0:255];
  int          n_acc = 0, n_rd = 0, n_done = 0, cyc = 0;
  int          occ = 0, occ_err = 0, stab_err = 0;
  logic        hold = 1'b0, h_last = 1'b0;
  logic [31:0] h_data = '0;

  always @(negedge clk) begin
    if (m_valid && m_ready) begin
      acc_data[n_acc] = m_data;
      acc_last[n_acc] = m_last;
      acc_cyc[n_acc]  = cyc;
      n_acc = n_acc + 1;
    end
    if (fifo_rd_en) n_rd = n_rd + 1;
    if (pkt_done) n_done = n_done + 1;
    if (srst) begin
      occ  = 0;
      hold = 1'b0;
    end else begin
      if (occ > 4) occ_err = occ_err + 1;
      occ = occ + (fifo_rd_en ? 1 : 0) - ((m_valid && m_ready) ? 1 : 0);
      if (hold && (!m_valid || m_data !== h_data || m_last !== h_last)) stab_err = stab_err + 1;
      hold   = m_valid && !m_ready;
      h_data = m_data;
      h_last = m_last;
    end
    cyc = cyc + 1;
  end

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
    #1;
  endtask

  task automatic push_words(input logic [31:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      mem[tail] = base + 32'(i);
      tail = tail + 1;
    end
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int b, r0, d0;
    logic [3:0] pat;
    pat       = 4'b1001;
    srst      = 1'b1;
    m_ready   = 1'b0;
    cfg_len   = 16'd4;
    inj_valid = 1'b0;
    inj_dout  = '0;
    #1;
    chk("rst_m_valid", 32'(m_valid), 0);
    chk("rst_rd_en", 32'(fifo_rd_en), 0);
    chk("rst_m_data", m_data, 0);
    chk("rst_m_last", 32'(m_last), 0);
    chk("rst_pkt_done", 32'(pkt_done), 0);
    chk("rst_err", 32'(err), 0);
    tick(2);
    srst = 1'b0;
    at_neg();
    chk("idle_m_valid", 32'(m_valid), 0);

    // Test 1: 8 words, len 4, ready held high
    tick(1);
    m_ready = 1'b1;
    b = n_acc; d0 = n_done;
    push_words(32'h10, 8);
    at_neg();
    chk("t1_rd_en_first", 32'(fifo_rd_en), 1);
    chk("t1_valid_c0", 32'(m_valid), 0);
    at_neg();
    chk("t1_valid_c1", 32'(m_valid), 0);
    at_neg();
    chk("t1_valid_c2", 32'(m_valid), 1);
    chk("t1_first_data", m_data, 32'h10);
    tick(12);
    chk("t1_count", 32'(n_acc - b), 8);
    for (int i = 0; i < 8; i++) begin
      chk("t1_data", acc_data[b+i], 32'h10 + 32'(i));
      chk("t1_last", 32'(acc_last[b+i]), (i == 3 || i == 7) ? 1 : 0);
    end
    chk("t1_rate", 32'(acc_cyc[b+7] - acc_cyc[b]), 7);
    chk("t1_pkt_done", 32'(n_done - d0), 2);
    chk("t1_err", 32'(err), 0);

    // Test 2: ready pattern 1,0,0,1
    b = n_acc; d0 = n_done;
    push_words(32'h10, 8);
    for (int i = 0; i < 40; i++) begin
      m_ready = pat[i % 4];
      tick(1);
    end
    m_ready = 1'b1;
    tick(4);
    chk("t2_count", 32'(n_acc - b), 8);
    for (int i = 0; i < 8; i++) begin
      chk("t2_data", acc_data[b+i], 32'h10 + 32'(i));
      chk("t2_last", 32'(acc_last[b+i]), (i == 3 || i == 7) ? 1 : 0);
    end
    chk("t2_pkt_done", 32'(n_done - d0), 2);
    chk("t2_occupancy", 32'(occ_err), 0);
    chk("t2_stable", 32'(stab_err), 0);

    // Test 3: ready low for 20 cycles, then release
    m_ready = 1'b0;
    r0 = n_rd;
    push_words(32'h20, 8);
    tick(20);
    at_neg();
    chk("t3_rd_pulses", 32'(n_rd - r0), 4);
    chk("t3_rd_en_low", 32'(fifo_rd_en), 0);
    chk("t3_head", m_data, 32'h20);
    tick(1);
    b = n_acc;
    m_ready = 1'b1;
    tick(12);
    chk("t3_count", 32'(n_acc - b), 8);
    for (int i = 0; i < 8; i++) begin
      chk("t3_data", acc_data[b+i], 32'h20 + 32'(i));
      chk("t3_last", 32'(acc_last[b+i]), (i == 3 || i == 7) ? 1 : 0);
    end
    chk("t3_rate", 32'(acc_cyc[b+7] - acc_cyc[b]), 7);
    chk("t3_occupancy", 32'(occ_err), 0);
    chk("t3_stable", 32'(stab_err), 0);

    // Test 4: cfg_len 0 behaves as 1
    cfg_len = 16'd0;
    b = n_acc; d0 = n_done;
    push_words(32'hA, 2);
    tick(6);
    chk("t4_count", 32'(n_acc - b), 2);
    chk("t4_data0", acc_data[b], 32'hA);
    chk("t4_last0", 32'(acc_last[b]), 1);
    chk("t4_data1", acc_data[b+1], 32'hB);
    chk("t4_last1", 32'(acc_last[b+1]), 1);
    chk("t4_pkt_done", 32'(n_done - d0), 2);
    chk("t4_err", 32'(err), 0);

    // Test 5: unsolicited fifo_valid
    inj_valid = 1'b1;
    inj_dout  = 32'h55;
    at_neg();
    chk("t5_err_before", 32'(err), 0);
    tick(1);
    inj_valid = 1'b0;
    at_neg();
    chk("t5_err_set", 32'(err), 1);
    tick(5);
    chk("t5_err_sticky", 32'(err), 1);

    // Test 6: async reset in the middle of a packet
    cfg_len = 16'd4;
    m_ready = 1'b0;
    push_words(32'h30, 8);
    tick(6);
    m_ready = 1'b1;
    tick(2);
    m_ready = 1'b0;
    tick(4);
    at_neg();
    chk("t6_pre_valid", 32'(m_valid), 1);
    chk("t6_pre_data", m_data, 32'h32);
    chk("t6_pre_last", 32'(m_last), 0);
    chk("t6_pre_err", 32'(err), 1);
    #1;
    srst = 1'b1;
    #1;
    chk("t6_async_valid", 32'(m_valid), 0);
    chk("t6_async_rd_en", 32'(fifo_rd_en), 0);
    chk("t6_async_last", 32'(m_last), 0);
    chk("t6_async_err", 32'(err), 0);
    chk("t6_async_data", m_data, 0);
    cfg_len = 16'd1;
    tick(2);
    at_neg();
    chk("t6_held_valid", 32'(m_valid), 0);
    #1;
    srst = 1'b0;
    b = n_acc; d0 = n_done;
    m_ready = 1'b1;
    tick(8);
    chk("t6_count", 32'(n_acc - b), 2);
    chk("t6_data0", acc_data[b], 32'h36);
    chk("t6_last0", 32'(acc_last[b]), 1);
    chk("t6_data1", acc_data[b+1], 32'h37);
    chk("t6_last1", 32'(acc_last[b+1]), 1);
    chk("t6_pkt_done", 32'(n_done - d0), 2);
    chk("t6_err", 32'(err), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
